// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and helpers for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;
   localparam int unsigned ITER  = 32;
   localparam int unsigned CNT_W = $clog2(ITER);

   typedef logic [1:0] op_t;
   localparam op_t OP_MULTU = 2'b00;
   localparam op_t OP_MULT  = 2'b01;
   localparam op_t OP_DIVU  = 2'b10;
   localparam op_t OP_DIV   = 2'b11;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_PREP = 2'd1;
   localparam state_t ST_CALC = 2'd2;
   localparam state_t ST_FIX  = 2'd3;

   localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

   function automatic logic [31:0] mag32(input logic is_signed, input logic [31:0] v);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction
endpackage

// File: rtl/muldiv_if.sv
// EX-stage side of the multiply/divide unit: op issue, mt writes, mf reads, HI/LO and stall.
interface muldiv_if;
   logic        op_valid;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        mthi_we;
   logic        mtlo_we;
   logic [31:0] mt_data;
   logic        rd_req;
   logic        rd_sel;
   logic [31:0] rd_data;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall;

   modport master (
      output op_valid, op, a, b, mthi_we, mtlo_we, mt_data, rd_req, rd_sel,
      input  rd_data, hi, lo, busy, stall
   );

   modport slave (
      input  op_valid, op, a, b, mthi_we, mtlo_we, mt_data, rd_req, rd_sel,
      output rd_data, hi, lo, busy, stall
   );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply (LSB first) or restoring divide step.
module muldiv_step (
   input  logic [63:0] i_acc,
   input  logic [31:0] i_dvs,
   input  logic        i_is_div,
   output logic [63:0] o_acc
);
   logic [32:0] w_sum;
   logic [32:0] w_sh;
   logic [33:0] w_diff;
   logic        w_neg;

   always_comb begin
      w_sum  = {1'b0, i_acc[63:32]} + (i_acc[0] ? {1'b0, i_dvs} : 33'd0);
      // Partial remainder is below the divisor, so the shifted value fits in 33 bits
      w_sh   = i_acc[63:31];
      w_diff = {1'b0, w_sh} - {2'b00, i_dvs};
      w_neg  = w_diff[33];
      if (i_is_div)
         o_acc = {(w_neg ? w_sh[31:0] : w_diff[31:0]), i_acc[30:0], ~w_neg};
      else
         o_acc = {w_sum, i_acc[31:1]};
   end
endmodule

// File: rtl/muldiv_seq.sv
// HI/LO owner: mult/div take 34 busy cycles (PREP, 32x CALC, FIX); dependent
// requests seen while busy raise stall and are re-presented by the pipeline.
module muldiv_seq
   import muldiv_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   muldiv_if.slave bus
);
   state_t           r_state;
   op_t              r_op;
   logic [31:0]      r_a;
   logic [31:0]      r_b;
   logic [31:0]      r_dvs;
   logic [63:0]      r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;

   logic        w_is_div;
   logic        w_busy;
   logic [63:0] w_acc_nxt;
   logic [63:0] w_prod;
   logic [31:0] w_quo;
   logic [31:0] w_rem;

   assign w_is_div = r_op[1];
   assign w_busy   = (r_state != ST_IDLE);
   assign w_prod   = r_neg_q ? (~r_acc + 64'd1) : r_acc;
   assign w_quo    = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
   assign w_rem    = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

   muldiv_step u_step (
      .i_acc    (r_acc),
      .i_dvs    (r_dvs),
      .i_is_div (w_is_div),
      .o_acc    (w_acc_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_op    <= OP_MULTU;
         r_a     <= '0;
         r_b     <= '0;
         r_dvs   <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.mthi_we) r_hi <= bus.mt_data;
               if (bus.mtlo_we) r_lo <= bus.mt_data;
               if (bus.op_valid) begin
                  r_op    <= bus.op;
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_state <= ST_PREP;
               end
            end
            ST_PREP: begin
               // Upper half cleared; lower half holds the multiplier / dividend magnitude
               r_acc   <= {32'h0, mag32(r_op[0], r_a)};
               r_dvs   <= mag32(r_op[0], r_b);
               r_neg_q <= r_op[0] & (r_a[31] ^ r_b[31]);
               r_neg_r <= r_op[0] & r_a[31];
               r_cnt   <= '0;
               r_state <= ST_CALC;
            end
            ST_CALC: begin
               r_acc <= w_acc_nxt;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(ITER - 1)) r_state <= ST_FIX;
            end
            default: begin
               if (!w_is_div) begin
                  r_hi <= w_prod[63:32];
                  r_lo <= w_prod[31:0];
               end else if (r_b == 32'h0) begin
                  r_hi <= r_a;
                  r_lo <= DIV0_LO;
               end else begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.hi      = r_hi;
   assign bus.lo      = r_lo;
   assign bus.busy    = w_busy;
   assign bus.stall   = w_busy & (bus.op_valid | bus.rd_req | bus.mthi_we | bus.mtlo_we);
   assign bus.rd_data = bus.rd_sel ? r_hi : r_lo;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboarded bench for muldiv_seq: directed mult/div vectors, stall, mt writes, reset abort.
module tb_muldiv_seq;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [63:0] exp_q[$];

   muldiv_if bus();

   muldiv_seq u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Drives an op for one accept edge; caller starts in a cycle where the unit is idle
   task automatic issue(input op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input bit push);
      bus.op_valid = 1'b1;
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      if (push) exp_q.push_back({ehi, elo});
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0;
      chk("busy_after_accept", {63'd0, bus.busy}, 64'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
      chk("idle_wait", {63'd0, bus.busy}, 64'd0);
   endtask

   // Monitor: on every busy->idle transition, check busy length and the scoreboard head
   initial begin
      logic        prev = 1'b0;
      int          bcnt = 0;
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b0;
            bcnt = 0;
         end else begin
            if (bus.busy) bcnt++;
            if (prev && !bus.busy) begin
               chk("busy_cycles", 64'(bcnt), 64'd34);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_result: hi=%h lo=%h with empty scoreboard", bus.hi, bus.lo);
               end else begin
                  e = exp_q.pop_front();
                  chk("result_hi", {32'd0, bus.hi}, {32'd0, e[63:32]});
                  chk("result_lo", {32'd0, bus.lo}, {32'd0, e[31:0]});
               end
               bcnt = 0;
            end
            prev = bus.busy;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.op_valid = 1'b0;
      bus.op       = OP_MULTU;
      bus.a        = '0;
      bus.b        = '0;
      bus.mthi_we  = 1'b0;
      bus.mtlo_we  = 1'b0;
      bus.mt_data  = '0;
      bus.rd_req   = 1'b1;
      bus.rd_sel   = 1'b1;
      #2;
      chk("rst_hi",      {32'd0, bus.hi},      64'd0);
      chk("rst_lo",      {32'd0, bus.lo},      64'd0);
      chk("rst_busy",    {63'd0, bus.busy},    64'd0);
      chk("rst_stall",   {63'd0, bus.stall},   64'd0);
      chk("rst_rd_data", {32'd0, bus.rd_data}, 64'd0);
      bus.rd_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
      wait_idle();
      issue(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
      wait_idle();
      // Back-to-back: presented in the first cycle after the FIX edge
      issue(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'hE,         1'b1);
      wait_idle();
      issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
      wait_idle();
      issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b1);
      wait_idle();
      issue(OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
      wait_idle();
      issue(OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
      wait_idle();

      // mfhi held from after E3: stall spans the rest of busy, then new HI reads out
      issue(OP_MULTU, 32'h0001_0000, 32'h0003_0000, 32'd3, 32'd0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      bus.rd_req = 1'b1;
      bus.rd_sel = 1'b1;
      n = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!bus.busy) break;
         if (bus.stall) n++;
      end
      chk("stall_cycles",  64'(n), 64'd31);
      chk("stall_release", {63'd0, bus.stall},   64'd0);
      chk("rd_new_hi",     {32'd0, bus.rd_data}, 64'd3);
      bus.rd_req = 1'b0;
      bus.rd_sel = 1'b0;

      bus.mtlo_we = 1'b1;
      bus.mt_data = 32'h1234;
      @(posedge clk);
      #1;
      bus.mtlo_we = 1'b0;
      chk("mtlo_lo",      {32'd0, bus.lo},      64'h1234);
      chk("mtlo_rd_data", {32'd0, bus.rd_data}, 64'h1234);
      chk("mtlo_hi_kept", {32'd0, bus.hi},      64'd3);

      // Reset in CALC at E10 discards the operation
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
      bus.rd_req = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("pre_abort_stall", {63'd0, bus.stall}, 64'd1);
      rst = 1'b1;
      #1;
      chk("abort_busy",  {63'd0, bus.busy},  64'd0);
      chk("abort_stall", {63'd0, bus.stall}, 64'd0);
      chk("abort_hi",    {32'd0, bus.hi},    64'd0);
      chk("abort_lo",    {32'd0, bus.lo},    64'd0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      bus.rd_req = 1'b0;
      @(posedge clk);
      #1;
      issue(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1);
      wait_idle();

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core. It accepts mult/multu/div/divu from the EX stage and computes one result bit per cycle. It writes HI/LO on completion and serves mfhi/mflo/mthi/mtlo. While an operation is in flight it raises a stall request to the hazard logic for any dependent instruction.

## Interface
- ITER, 32, iteration count; equals operand width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  mult/div instruction present in EX.
- op  in  2  00 multu, 01 mult, 10 divu, 11 div.
- a, b  in  32 each  rs and rt operand values.
- mthi_we, mtlo_we  in  1 each  mthi or mtlo present in EX.
- mt_data  in  32  data for mthi/mtlo.
- rd_req  in  1  mfhi or mflo present in EX.
- rd_sel  in  1  0 selects LO, 1 selects HI.
- rd_data  out  32  combinational read of the selected register.
- hi, lo  out  32 each  architectural HI/LO.
- busy  out  1  operation in flight.
- stall  out  1  freeze IF/ID/EX; insert a bubble into MEM.

## Operation
- FSM states: IDLE, PREP, CALC, FIX. busy = (state != IDLE).
- **IDLE:**
  - op_valid → latch a, b, op; go to PREP.
  - mthi_we / mtlo_we write hi / lo at the same edge, even if op_valid is also high; the op result later overwrites them.
- **PREP:**
  - Signed ops (op[0]=1) convert operands to magnitudes.
  - Record sign flags: product/quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Clear the 64-bit accumulator; count = 0; go to CALC.
- **CALC:** one step per cycle; count increments; on count == ITER-1 go to FIX.
  - Multiply: shift-add, LSB of multiplier first.
  - Divide: restoring; shift remainder left, subtract divisor, set quotient bit when non-negative.
- **FIX:**
  - Apply the sign flags (two's-complement negation).
  - Multiply writes hi/lo = product[63:32] / product[31:0].
  - Divide writes lo = quotient, hi = remainder.
  - Return to IDLE.
- **Divide by zero** (b == 0, either signedness): lo = 32'hFFFF_FFFF, hi = original a; no sign fixup.
- **div 0x8000_0000 / -1:** lo = 0x8000_0000, hi = 0; this is the natural magnitude result, with no special trap.
- **stall** = busy & (op_valid | rd_req | mthi_we | mtlo_we).
  - It is independent of rd_sel.
  - Stalled requests are held by the pipeline and re-presented.
- **rd_data** comes from the registered hi/lo. There is no bypass of an mt write occurring in the same cycle.

## Timing
- Reset: state = IDLE; hi = lo = 0; busy = stall = 0; rd_data = 0; count = 0; accumulator = 0.
- Accept edge E0 (IDLE & op_valid).
  - PREP occupies the cycle after E0.
  - CALC occupies edges E2..E33.
  - The FIX edge E34 updates hi/lo and returns to IDLE.
- busy is high for exactly 34 cycles after E0.
- A new op presented in the first cycle after E34 is accepted with no gap.
- A dependent instruction stalled during busy sees stall low, and the new hi/lo on rd_data, in the first cycle after E34.
- rst asserted mid-operation aborts immediately:
  - hi/lo clear to 0; the partial result is discarded.
  - The first op_valid after rst deasserts is accepted normally.

## Structure
- Shared package muldiv_pkg holds:
  - op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - the state enum;
  - ITER;
  - the divide-by-zero LO constant.
- Sub-module muldiv_step: combinational single-iteration unit.
  - Inputs: accumulator, divisor/multiplicand, is_div.
  - Outputs: the next accumulator.
  - The FSM, counter, sign logic and HI/LO registers stay in muldiv_seq.

## Test plan
- multu 0xFFFF_FFFF × 0xFFFF_FFFF → busy 34 cycles, then hi = 0xFFFF_FFFE, lo = 0x0000_0001.
- mult −3 × 7 → hi = 0xFFFF_FFFF, lo = 0xFFFF_FFEB; then back-to-back divu 100/7 accepted the next cycle → lo = 0xE, hi = 0x2.
- div −7/2 → lo = 0xFFFF_FFFD, hi = 0xFFFF_FFFF; div 0x8000_0000 / 0xFFFF_FFFF → lo = 0x8000_0000, hi = 0.
- divu 5/0 → lo = 0xFFFF_FFFF, hi = 5; div 0xFFFF_FFF9/0 → lo = 0xFFFF_FFFF, hi = 0xFFFF_FFF9.
- rd_req (rd_sel = 1) held from cycle E0+3 → stall high through E34; in the cycle after E34, stall = 0 and rd_data = new hi.
  - Also: mtlo_we with 0x1234 while idle → lo = 0x1234 after that edge.
- rst pulsed in CALC at E10 → busy = stall = 0, hi = lo = 0 asynchronously.
  - A subsequent multu 2×3 gives lo = 6, hi = 0 after 34 cycles.
